// File: rtl/simulation_wrapper.sv
// AXI-Lite controlled stream multiplier: MM2S slave loads CTRL/DATA, an internal stream
// multiplies each word by an 8-bit constant, and the S2MM slave exposes status, counters and results.

module simulation_wrapper_axil_port #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    output logic                wr_en,
    output logic [7:0]          wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W/8-1:0] wr_strb,
    output logic [7:0]          rd_addr,
    input  logic [DATA_W-1:0]   rd_data
);
    logic       live;
    logic       aw_pend;
    logic [7:0] aw_addr_q;
    logic       unused_addr_bits;

    // live keeps every ready low while in reset and rises on the first clock after release
    assign awready = live & ~aw_pend;
    assign wready  = live & aw_pend & ~bvalid;
    assign arready = live & ~rvalid;
    assign bresp   = 2'b00;
    assign rresp   = 2'b00;
    assign wr_en   = wvalid & wready;
    assign wr_addr = aw_addr_q;
    assign wr_data = wdata;
    assign wr_strb = wstrb;
    assign rd_addr = araddr[7:0];
    assign unused_addr_bits = ^{awaddr[ADDR_W-1:8], araddr[ADDR_W-1:8]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            live      <= 1'b0;
            aw_pend   <= 1'b0;
            aw_addr_q <= '0;
            bvalid    <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
        end else begin
            live <= 1'b1;
            if (awvalid && awready) begin
                aw_pend   <= 1'b1;
                aw_addr_q <= awaddr[7:0];
            end else if (wr_en) begin
                aw_pend <= 1'b0;
            end
            if (wr_en)
                bvalid <= 1'b1;
            else if (bready)
                bvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= rd_data;
            end else if (rready) begin
                rvalid <= 1'b0;
            end
        end
    end
endmodule

module simulation_wrapper #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ADDR_W-1:0]   s_axi_mm2s_awaddr,
    input  logic                s_axi_mm2s_awvalid,
    output logic                s_axi_mm2s_awready,
    input  logic [DATA_W-1:0]   s_axi_mm2s_wdata,
    input  logic [DATA_W/8-1:0] s_axi_mm2s_wstrb,
    input  logic                s_axi_mm2s_wvalid,
    output logic                s_axi_mm2s_wready,
    output logic [1:0]          s_axi_mm2s_bresp,
    output logic                s_axi_mm2s_bvalid,
    input  logic                s_axi_mm2s_bready,
    input  logic [ADDR_W-1:0]   s_axi_mm2s_araddr,
    input  logic                s_axi_mm2s_arvalid,
    output logic                s_axi_mm2s_arready,
    output logic [DATA_W-1:0]   s_axi_mm2s_rdata,
    output logic [1:0]          s_axi_mm2s_rresp,
    output logic                s_axi_mm2s_rvalid,
    input  logic                s_axi_mm2s_rready,
    input  logic [ADDR_W-1:0]   s_axi_s2mm_awaddr,
    input  logic                s_axi_s2mm_awvalid,
    output logic                s_axi_s2mm_awready,
    input  logic [DATA_W-1:0]   s_axi_s2mm_wdata,
    input  logic [DATA_W/8-1:0] s_axi_s2mm_wstrb,
    input  logic                s_axi_s2mm_wvalid,
    output logic                s_axi_s2mm_wready,
    output logic [1:0]          s_axi_s2mm_bresp,
    output logic                s_axi_s2mm_bvalid,
    input  logic                s_axi_s2mm_bready,
    input  logic [ADDR_W-1:0]   s_axi_s2mm_araddr,
    input  logic                s_axi_s2mm_arvalid,
    output logic                s_axi_s2mm_arready,
    output logic [DATA_W-1:0]   s_axi_s2mm_rdata,
    output logic [1:0]          s_axi_s2mm_rresp,
    output logic                s_axi_s2mm_rvalid,
    input  logic                s_axi_s2mm_rready
);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(MAX_WORDS);

    function automatic logic [DATA_W-1:0] apply_strb(input logic [DATA_W-1:0] old_v,
                                                     input logic [DATA_W-1:0] new_v,
                                                     input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int b = 0; b < STRB_W; b++)
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    // Unsigned product reduced modulo 2^DATA_W, i.e. the low DATA_W bits
    function automatic logic [DATA_W-1:0] mul_trunc(input logic [DATA_W-1:0] a,
                                                    input logic [7:0] k);
        return a * {{(DATA_W-8){1'b0}}, k};
    endfunction

    logic                mm_wr_en, s2_wr_en;
    logic [7:0]          mm_wr_addr, s2_wr_addr, mm_rd_addr, s2_rd_addr;
    logic [DATA_W-1:0]   mm_wr_data, s2_wr_data, mm_rd_data, s2_rd_data;
    logic [STRB_W-1:0]   mm_wr_strb, s2_wr_strb;

    logic [11:0]         ctrl;
    logic [DATA_W-1:0]   data_mem   [MAX_WORDS];
    logic [DATA_W-1:0]   result_mem [MAX_WORDS];
    logic                rdy_flag;
    logic [DATA_W-1:0]   word_cnt, frame_cnt;

    logic                wr_is_data;
    logic [IDX_W-1:0]    wr_idx;
    logic [2:0]          n_eff;
    logic                trigger, rdy_set, rdy_clr;

    logic                eng_busy, stream_on;
    logic [IDX_W-1:0]    rd_ptr;
    logic [2:0]          n_snap;
    logic [7:0]          const_snap;

    logic                vld_p0, last_p0, vld_p1, last_p1;
    logic [IDX_W-1:0]    idx_p0, idx_p1;
    logic [DATA_W-1:0]   tdata_p0, prod_p1;
    logic                unused_s2_bits;

    simulation_wrapper_axil_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mm2s (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(s_axi_mm2s_awaddr), .awvalid(s_axi_mm2s_awvalid), .awready(s_axi_mm2s_awready),
        .wdata(s_axi_mm2s_wdata), .wstrb(s_axi_mm2s_wstrb), .wvalid(s_axi_mm2s_wvalid),
        .wready(s_axi_mm2s_wready), .bresp(s_axi_mm2s_bresp), .bvalid(s_axi_mm2s_bvalid),
        .bready(s_axi_mm2s_bready), .araddr(s_axi_mm2s_araddr), .arvalid(s_axi_mm2s_arvalid),
        .arready(s_axi_mm2s_arready), .rdata(s_axi_mm2s_rdata), .rresp(s_axi_mm2s_rresp),
        .rvalid(s_axi_mm2s_rvalid), .rready(s_axi_mm2s_rready),
        .wr_en(mm_wr_en), .wr_addr(mm_wr_addr), .wr_data(mm_wr_data), .wr_strb(mm_wr_strb),
        .rd_addr(mm_rd_addr), .rd_data(mm_rd_data)
    );

    simulation_wrapper_axil_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_s2mm (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(s_axi_s2mm_awaddr), .awvalid(s_axi_s2mm_awvalid), .awready(s_axi_s2mm_awready),
        .wdata(s_axi_s2mm_wdata), .wstrb(s_axi_s2mm_wstrb), .wvalid(s_axi_s2mm_wvalid),
        .wready(s_axi_s2mm_wready), .bresp(s_axi_s2mm_bresp), .bvalid(s_axi_s2mm_bvalid),
        .bready(s_axi_s2mm_bready), .araddr(s_axi_s2mm_araddr), .arvalid(s_axi_s2mm_arvalid),
        .arready(s_axi_s2mm_arready), .rdata(s_axi_s2mm_rdata), .rresp(s_axi_s2mm_rresp),
        .rvalid(s_axi_s2mm_rvalid), .rready(s_axi_s2mm_rready),
        .wr_en(s2_wr_en), .wr_addr(s2_wr_addr), .wr_data(s2_wr_data), .wr_strb(s2_wr_strb),
        .rd_addr(s2_rd_addr), .rd_data(s2_rd_data)
    );

    assign unused_s2_bits = ^{s2_wr_data[DATA_W-1:1], s2_wr_strb[STRB_W-1:1]};

    always_comb begin
        wr_is_data = 1'b0;
        wr_idx     = '0;
        for (int i = 0; i < MAX_WORDS; i++) begin
            if (mm_wr_addr == 8'(4 + 4*i)) begin
                wr_is_data = 1'b1;
                wr_idx     = IDX_W'(i);
            end
        end
    end

    // Word counts above MAX_WORDS saturate; zero never starts a frame
    assign n_eff   = (ctrl[10:8] > 3'(MAX_WORDS)) ? 3'(MAX_WORDS) : ctrl[10:8];
    assign trigger = mm_wr_en && wr_is_data && ctrl[11] && !eng_busy &&
                     (n_eff != 3'd0) && (3'(wr_idx) == n_eff - 3'd1);
    assign rdy_set = vld_p1 && last_p1;
    assign rdy_clr = s2_wr_en && (s2_wr_addr == 8'h00) && s2_wr_strb[0] && s2_wr_data[0];

    always_comb begin
        mm_rd_data = '0;
        if (mm_rd_addr == 8'h00)
            mm_rd_data = {{(DATA_W-12){1'b0}}, ctrl};
        for (int i = 0; i < MAX_WORDS; i++)
            if (mm_rd_addr == 8'(4 + 4*i)) mm_rd_data = data_mem[i];
    end

    always_comb begin
        s2_rd_data = '0;
        case (s2_rd_addr)
            8'h00:   s2_rd_data = {{(DATA_W-1){1'b0}}, rdy_flag};
            8'h04:   s2_rd_data = word_cnt;
            8'h08:   s2_rd_data = frame_cnt;
            default: s2_rd_data = '0;
        endcase
        for (int i = 0; i < MAX_WORDS; i++)
            if (s2_rd_addr == 8'(12 + 4*i)) s2_rd_data = result_mem[i];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ctrl <= '0;
            for (int i = 0; i < MAX_WORDS; i++) data_mem[i] <= '0;
        end else if (mm_wr_en) begin
            if (mm_wr_addr == 8'h00) begin
                if (mm_wr_strb[0]) ctrl[7:0]  <= mm_wr_data[7:0];
                if (mm_wr_strb[1]) ctrl[11:8] <= mm_wr_data[11:8];
            end
            if (wr_is_data)
                data_mem[wr_idx] <= apply_strb(data_mem[wr_idx], mm_wr_data, mm_wr_strb);
        end
    end

    // Stage p0: stream source reads DATA[rd_ptr]
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            eng_busy   <= 1'b0;
            stream_on  <= 1'b0;
            rd_ptr     <= '0;
            n_snap     <= '0;
            const_snap <= '0;
            vld_p0     <= 1'b0;
            last_p0    <= 1'b0;
            idx_p0     <= '0;
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            idx_p1     <= '0;
        end else begin
            if (trigger) begin
                eng_busy   <= 1'b1;
                stream_on  <= 1'b1;
                rd_ptr     <= '0;
                n_snap     <= n_eff;
                const_snap <= ctrl[7:0];
            end else begin
                if (stream_on) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    if (3'(rd_ptr) == n_snap - 3'd1) stream_on <= 1'b0;
                end
                if (rdy_set) eng_busy <= 1'b0;
            end
            vld_p0  <= stream_on;
            last_p0 <= stream_on && (3'(rd_ptr) == n_snap - 3'd1);
            idx_p0  <= rd_ptr;
            vld_p1  <= vld_p0;
            last_p1 <= last_p0;
            idx_p1  <= idx_p0;
        end
    end

    // Stage p1: multiply by the snapshotted constant
    always_ff @(posedge aclk) begin
        tdata_p0 <= data_mem[rd_ptr];
        prod_p1  <= mul_trunc(tdata_p0, const_snap);
    end

    // Stage p2: capture result, update status and statistics
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdy_flag  <= 1'b0;
            word_cnt  <= '0;
            frame_cnt <= '0;
            for (int i = 0; i < MAX_WORDS; i++) result_mem[i] <= '0;
        end else begin
            if (vld_p1) result_mem[idx_p1] <= prod_p1;
            if (rdy_set) begin
                rdy_flag  <= 1'b1;
                word_cnt  <= word_cnt + {{(DATA_W-3){1'b0}}, n_snap};
                frame_cnt <= frame_cnt + 1'b1;
            end else if (rdy_clr) begin
                rdy_flag <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_simulation_wrapper.sv
// Directed bench for simulation_wrapper: drives both AXI-Lite slaves and checks
// readback against hand-computed values with immediate assertions.

module tb_simulation_wrapper;
    localparam int TMO = 20;
    localparam int MM = 0;
    localparam int S2 = 1;

    logic        aclk;
    logic        aresetn;
    logic [31:0] awaddr [2];
    logic [31:0] wdata  [2];
    logic [3:0]  wstrb  [2];
    logic [31:0] araddr [2];
    logic [31:0] rdata  [2];
    logic [1:0]  bresp  [2];
    logic [1:0]  rresp  [2];
    logic [1:0]  awvalid, wvalid, bready, arvalid, rready;
    logic [1:0]  awready, wready, bvalid, arready, rvalid;

    int n_assert = 0;
    int n_fail   = 0;

    simulation_wrapper #(.ADDR_W(32), .DATA_W(32), .MAX_WORDS(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_mm2s_awaddr(awaddr[0]), .s_axi_mm2s_awvalid(awvalid[0]), .s_axi_mm2s_awready(awready[0]),
        .s_axi_mm2s_wdata(wdata[0]), .s_axi_mm2s_wstrb(wstrb[0]), .s_axi_mm2s_wvalid(wvalid[0]),
        .s_axi_mm2s_wready(wready[0]), .s_axi_mm2s_bresp(bresp[0]), .s_axi_mm2s_bvalid(bvalid[0]),
        .s_axi_mm2s_bready(bready[0]), .s_axi_mm2s_araddr(araddr[0]), .s_axi_mm2s_arvalid(arvalid[0]),
        .s_axi_mm2s_arready(arready[0]), .s_axi_mm2s_rdata(rdata[0]), .s_axi_mm2s_rresp(rresp[0]),
        .s_axi_mm2s_rvalid(rvalid[0]), .s_axi_mm2s_rready(rready[0]),
        .s_axi_s2mm_awaddr(awaddr[1]), .s_axi_s2mm_awvalid(awvalid[1]), .s_axi_s2mm_awready(awready[1]),
        .s_axi_s2mm_wdata(wdata[1]), .s_axi_s2mm_wstrb(wstrb[1]), .s_axi_s2mm_wvalid(wvalid[1]),
        .s_axi_s2mm_wready(wready[1]), .s_axi_s2mm_bresp(bresp[1]), .s_axi_s2mm_bvalid(bvalid[1]),
        .s_axi_s2mm_bready(bready[1]), .s_axi_s2mm_araddr(araddr[1]), .s_axi_s2mm_arvalid(arvalid[1]),
        .s_axi_s2mm_arready(arready[1]), .s_axi_s2mm_rdata(rdata[1]), .s_axi_s2mm_rresp(rresp[1]),
        .s_axi_s2mm_rvalid(rvalid[1]), .s_axi_s2mm_rready(rready[1])
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input int s, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_delay, input int b_hold);
        bit ok;
        @(posedge aclk); #1;
        awaddr[s] = addr; awvalid[s] = 1'b1;
        wdata[s] = data; wstrb[s] = strb; wvalid[s] = (w_delay == 0);
        ok = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge aclk);
            if (awready[s]) begin ok = 1; break; end
        end
        check("aw_handshake", 64'(ok), 64'd1);
        @(posedge aclk); #1;
        awvalid[s] = 1'b0;
        if (w_delay > 0) begin
            repeat (w_delay) @(posedge aclk);
            #1 wvalid[s] = 1'b1;
        end
        ok = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge aclk);
            if (wready[s]) begin ok = 1; break; end
        end
        check("w_handshake", 64'(ok), 64'd1);
        @(posedge aclk); #1;
        wvalid[s] = 1'b0;
        for (int i = 0; i < b_hold; i++) begin
            @(negedge aclk);
            check("bvalid_held", 64'(bvalid[s]), 64'd1);
        end
        ok = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge aclk);
            if (bvalid[s]) begin ok = 1; break; end
        end
        check("bvalid_seen", 64'(ok), 64'd1);
        check("bresp", 64'(bresp[s]), 64'd0);
        bready[s] = 1'b1;
        @(posedge aclk); #1;
        bready[s] = 1'b0;
        check("bvalid_drop", 64'(bvalid[s]), 64'd0);
    endtask

    task automatic wr(input int s, input logic [31:0] addr, input logic [31:0] data);
        axi_write(s, addr, data, 4'hF, 0, 0);
    endtask

    task automatic rd_check(input int s, input logic [31:0] addr, input logic [31:0] exp,
                            input string tag);
        bit ok;
        @(posedge aclk); #1;
        araddr[s] = addr; arvalid[s] = 1'b1;
        ok = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge aclk);
            if (arready[s]) begin ok = 1; break; end
        end
        check("ar_handshake", 64'(ok), 64'd1);
        @(posedge aclk); #1;
        arvalid[s] = 1'b0;
        ok = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge aclk);
            if (rvalid[s]) begin ok = 1; break; end
        end
        check("rvalid_seen", 64'(ok), 64'd1);
        check("rresp", 64'(rresp[s]), 64'd0);
        check(tag, 64'(rdata[s]), 64'(exp));
        rready[s] = 1'b1;
        @(posedge aclk); #1;
        rready[s] = 1'b0;
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            awaddr[s] = '0; wdata[s] = '0; wstrb[s] = '0; araddr[s] = '0;
        end
        awvalid = '0; wvalid = '0; bready = '0; arvalid = '0; rready = '0;
        aresetn = 1'b1;
        #1 aresetn = 1'b0;
        repeat (5) @(posedge aclk);
        @(negedge aclk);
        check("reset_mm2s_outputs",
              64'({awready[0], wready[0], arready[0], bvalid[0], rvalid[0], bresp[0], rresp[0], rdata[0]}), 64'd0);
        check("reset_s2mm_outputs",
              64'({awready[1], wready[1], arready[1], bvalid[1], rvalid[1], bresp[1], rresp[1], rdata[1]}), 64'd0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        check("ready_after_release", 64'({awready, arready}), 64'hF);

        rd_check(S2, 32'h00, 32'd0, "reset_status");
        rd_check(S2, 32'h04, 32'd0, "reset_word_cnt");
        rd_check(S2, 32'h08, 32'd0, "reset_frame_cnt");

        // Frame 1: N=1, CONST=5
        wr(MM, 32'h00, 32'h905);
        wr(MM, 32'h04, 32'd1);
        repeat (5) @(posedge aclk);
        rd_check(S2, 32'h00, 32'd1, "f1_status");
        rd_check(S2, 32'h0C, 32'd5, "f1_result0");
        wr(S2, 32'h00, 32'd1);
        rd_check(S2, 32'h00, 32'd0, "f1_status_cleared");

        // Frame 2: N=4, CONST=8; DATA0 write must not trigger
        wr(MM, 32'h00, 32'hC08);
        wr(MM, 32'h04, 32'd1);
        wr(MM, 32'h08, 32'd2);
        wr(MM, 32'h0C, 32'd3);
        rd_check(S2, 32'h00, 32'd0, "f2_no_early_trigger");
        wr(MM, 32'h10, 32'd4);
        repeat (10) @(posedge aclk);
        rd_check(S2, 32'h00, 32'd1, "f2_status");
        rd_check(S2, 32'h0C, 32'd8, "f2_result0");
        rd_check(S2, 32'h10, 32'd16, "f2_result1");
        rd_check(S2, 32'h14, 32'd24, "f2_result2");
        rd_check(S2, 32'h18, 32'd32, "f2_result3");
        wr(S2, 32'h00, 32'd1);
        rd_check(S2, 32'h00, 32'd0, "f2_status_cleared");
        rd_check(S2, 32'h04, 32'd5, "word_cnt_after_2");
        rd_check(S2, 32'h08, 32'd2, "frame_cnt_after_2");

        // EN=0: data stored, no frame
        wr(MM, 32'h00, 32'h105);
        wr(MM, 32'h04, 32'd7);
        repeat (8) @(posedge aclk);
        rd_check(S2, 32'h00, 32'd0, "en0_status");
        rd_check(S2, 32'h04, 32'd5, "en0_word_cnt");
        rd_check(S2, 32'h08, 32'd2, "en0_frame_cnt");
        rd_check(S2, 32'h0C, 32'd8, "en0_result0_held");
        rd_check(MM, 32'h04, 32'd7, "en0_data0_stored");

        // WORD=0 never triggers
        wr(MM, 32'h00, 32'h800);
        wr(MM, 32'h04, 32'd9);
        repeat (8) @(posedge aclk);
        rd_check(S2, 32'h00, 32'd0, "word0_status");
        rd_check(S2, 32'h08, 32'd2, "word0_frame_cnt");

        // Truncated product: 0xFFFFFFFF * 0xFF
        wr(MM, 32'h00, 32'h9FF);
        wr(MM, 32'h04, 32'hFFFF_FFFF);
        repeat (5) @(posedge aclk);
        rd_check(S2, 32'h00, 32'd1, "trunc_status");
        rd_check(S2, 32'h0C, 32'hFFFF_FF01, "trunc_result0");
        rd_check(S2, 32'h04, 32'd6, "trunc_word_cnt");
        rd_check(S2, 32'h08, 32'd3, "trunc_frame_cnt");
        wr(S2, 32'h00, 32'd1);

        // WORD=7 behaves as 4, CONST=2, DATA = FFFFFFFF,2,3,4
        wr(MM, 32'h00, 32'hF02);
        wr(MM, 32'h10, 32'd4);
        repeat (10) @(posedge aclk);
        rd_check(S2, 32'h00, 32'd1, "w7_status");
        rd_check(S2, 32'h0C, 32'hFFFF_FFFE, "w7_result0");
        rd_check(S2, 32'h10, 32'd4, "w7_result1");
        rd_check(S2, 32'h14, 32'd6, "w7_result2");
        rd_check(S2, 32'h18, 32'd8, "w7_result3");
        rd_check(S2, 32'h04, 32'd10, "w7_word_cnt");
        rd_check(S2, 32'h08, 32'd4, "w7_frame_cnt");
        wr(S2, 32'h00, 32'd1);

        // Results are read-only; unmapped MM2S addresses
        wr(S2, 32'h0C, 32'h1234);
        rd_check(S2, 32'h0C, 32'hFFFF_FFFE, "result_readonly");
        wr(MM, 32'h40, 32'hDEAD_BEEF);
        rd_check(MM, 32'h40, 32'd0, "mm2s_unmapped_read");
        rd_check(MM, 32'h14, 32'd0, "mm2s_past_data3");

        // Delayed W, bready held low 2 cycles after bvalid
        axi_write(MM, 32'h00, 32'h0000_0A55, 4'hF, 3, 2);
        rd_check(MM, 32'h00, 32'hA55, "ctrl_delayed_w");
        axi_write(MM, 32'h00, 32'hFFFF_FFFF, 4'h1, 0, 0);
        rd_check(MM, 32'h00, 32'hAFF, "ctrl_strb_byte0");

        // Byte-enabled DATA1 write triggers N=2 with CONST=0xFF
        axi_write(MM, 32'h08, 32'hAABB_CCDD, 4'h4, 0, 0);
        rd_check(MM, 32'h08, 32'h00BB_0002, "data1_strb_byte2");
        repeat (6) @(posedge aclk);
        rd_check(S2, 32'h00, 32'd1, "n2_status");
        rd_check(S2, 32'h0C, 32'hFFFF_FF01, "n2_result0");
        rd_check(S2, 32'h10, 32'hBA45_01FE, "n2_result1");
        rd_check(S2, 32'h04, 32'd12, "n2_word_cnt");
        rd_check(S2, 32'h08, 32'd5, "n2_frame_cnt");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
